xgs_spi_arbiter: RTL and testbench

Shares the single XGS sensor SPI command master between up to NUM_REQ requesters (host register bridge, sensor init sequencer, validation status poller). It picks one pending register command by round-robin and forwards it to the SPI master. It then waits for completion or timeout and returns the read data or an error to the winning requester only. One transaction is in flight at a time.

---
 rtl/xgs_spi_arbiter.sv | 162 ++++++++++++++++
 tb/tb_xgs_spi_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgs_spi_arbiter.sv
// Round-robin arbiter sharing one XGS sensor SPI command master between NUM_REQ requesters.
// One command in flight at a time; the response or timeout error is returned to the winner only.
module xgs_spi_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                      sysclk,
    input  logic                      sysrst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rnw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_error,
    output logic                      spi_cmd_valid,
    input  logic                      spi_cmd_ready,
    output logic                      spi_cmd_rnw,
    output logic [ADDR_W-1:0]         spi_cmd_addr,
    output logic [DATA_W-1:0]         spi_cmd_wdata,
    input  logic                      spi_done,
    input  logic [DATA_W-1:0]         spi_rdata,
    output logic                      spi_abort,
    output logic                      busy,
    output logic [2:0]                owner,
    output logic [15:0]               timeout_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t              state_reg;
    logic [NUM_REQ-1:0]  req_ready_reg;
    logic [NUM_REQ-1:0]  rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic                rsp_error_reg;
    logic                spi_cmd_valid_reg;
    logic                spi_cmd_rnw_reg;
    logic [ADDR_W-1:0]   spi_cmd_addr_reg;
    logic [DATA_W-1:0]   spi_cmd_wdata_reg;
    logic                spi_abort_reg;
    logic                busy_reg;
    logic [2:0]          owner_reg;
    logic [IDX_W-1:0]    last_reg;
    logic [15:0]         timeout_cnt_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;
    logic [IDX_W-1:0]    winner_next;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Walk offsets from far to near so the requester closest after last_reg wins.
    always_comb begin
        winner_next = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            int cand;
            logic [IDX_W-1:0] cand_idx;
            cand = int'(last_reg) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_valid[cand_idx]) winner_next = cand_idx;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state_reg         <= ST_IDLE;
            req_ready_reg     <= '0;
            rsp_valid_reg     <= '0;
            rsp_rdata_reg     <= '0;
            rsp_error_reg     <= 1'b0;
            spi_cmd_valid_reg <= 1'b0;
            spi_cmd_rnw_reg   <= 1'b0;
            spi_cmd_addr_reg  <= '0;
            spi_cmd_wdata_reg <= '0;
            spi_abort_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            owner_reg         <= '0;
            last_reg          <= IDX_W'(NUM_REQ - 1);
            timeout_cnt_reg   <= '0;
            wait_cnt_reg      <= '0;
        end else begin
            req_ready_reg <= '0;
            spi_abort_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|req_valid) begin
                        spi_cmd_rnw_reg   <= req_rnw[winner_next];
                        spi_cmd_addr_reg  <= addr_arr[winner_next];
                        spi_cmd_wdata_reg <= wdata_arr[winner_next];
                        spi_cmd_valid_reg <= 1'b1;
                        req_ready_reg     <= NUM_REQ'(1) << winner_next;
                        owner_reg         <= 3'(winner_next);
                        last_reg          <= winner_next;
                        busy_reg          <= 1'b1;
                        state_reg         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (spi_cmd_ready) begin
                        spi_cmd_valid_reg <= 1'b0;
                        wait_cnt_reg      <= '0;
                        state_reg         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (spi_done) begin
                        rsp_rdata_reg <= spi_rdata;
                        rsp_error_reg <= 1'b0;
                        rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
                        state_reg     <= ST_RESP;
                    end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        spi_abort_reg <= 1'b1;
                        rsp_rdata_reg <= '0;
                        rsp_error_reg <= 1'b1;
                        if (timeout_cnt_reg != 16'hFFFF) timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                        state_reg     <= ST_RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // After an abort the response pulse is issued one cycle later than after a done.
                    if (|rsp_valid_reg) begin
                        rsp_valid_reg <= '0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end else begin
                        rsp_valid_reg <= NUM_REQ'(1) << owner_reg;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_error     = rsp_error_reg;
    assign spi_cmd_valid = spi_cmd_valid_reg;
    assign spi_cmd_rnw   = spi_cmd_rnw_reg;
    assign spi_cmd_addr  = spi_cmd_addr_reg;
    assign spi_cmd_wdata = spi_cmd_wdata_reg;
    assign spi_abort     = spi_abort_reg;
    assign busy          = busy_reg;
    assign owner         = owner_reg;
    assign timeout_cnt   = timeout_cnt_reg;

endmodule

// File: tb/tb_xgs_spi_arbiter.sv
// Directed bench for xgs_spi_arbiter: reset, write, round-robin, read data, backpressure/timeout, reset in WAIT.
module tb_xgs_spi_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 16;

    logic                      sysclk = 1'b0;
    logic                      sysrst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_rnw;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_error;
    logic                      spi_cmd_valid;
    logic                      spi_cmd_ready;
    logic                      spi_cmd_rnw;
    logic [ADDR_W-1:0]         spi_cmd_addr;
    logic [DATA_W-1:0]         spi_cmd_wdata;
    logic                      spi_done;
    logic [DATA_W-1:0]         spi_rdata;
    logic                      spi_abort;
    logic                      busy;
    logic [2:0]                owner;
    logic [15:0]               timeout_cnt;

    int checks   = 0;
    int failures = 0;

    xgs_spi_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .sysclk(sysclk), .sysrst(sysrst),
        .req_valid(req_valid), .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .spi_cmd_valid(spi_cmd_valid), .spi_cmd_ready(spi_cmd_ready), .spi_cmd_rnw(spi_cmd_rnw),
        .spi_cmd_addr(spi_cmd_addr), .spi_cmd_wdata(spi_cmd_wdata), .spi_done(spi_done),
        .spi_rdata(spi_rdata), .spi_abort(spi_abort), .busy(busy), .owner(owner),
        .timeout_cnt(timeout_cnt)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rnw, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata);
        req_rnw[i] = rnw;
        req_addr[i*ADDR_W +: ADDR_W]  = addr;
        req_wdata[i*DATA_W +: DATA_W] = wdata;
    endtask

    // Drives one transaction with immediate ready/done and reports what was observed.
    task automatic run_txn(input logic [2:0] vmask, input logic [15:0] rd,
                           output logic [2:0] rdy, output logic [2:0] rsp,
                           output logic [15:0] rdat, output logic err);
        req_valid = vmask;
        spi_cmd_ready = 1'b1;
        tick();
        rdy = req_ready;
        req_valid = vmask & ~rdy;
        tick();
        spi_done = 1'b1;
        spi_rdata = rd;
        tick();
        rsp = rsp_valid;
        rdat = rsp_rdata;
        err = rsp_error;
        spi_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic bad;
        bad = 1'b0;
        sysrst = 1'b1;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (req_ready !== 3'b000 || spi_cmd_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_ready: req_ready=%b spi_cmd_valid=%b required 000/0", req_ready, spi_cmd_valid);
        end
        checks++;
        if ({busy, owner, rsp_valid, rsp_error, spi_abort} !== 9'd0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b owner=%0d rsp_valid=%b rsp_error=%b spi_abort=%b required all 0",
                     busy, owner, rsp_valid, rsp_error, spi_abort);
        end
        checks++;
        if ({rsp_rdata, spi_cmd_rnw, spi_cmd_addr, spi_cmd_wdata, timeout_cnt} !== 64'd0) begin
            failures++;
            $display("FAIL reset_data: rsp_rdata=%h cmd_rnw=%b cmd_addr=%h cmd_wdata=%h timeout_cnt=%0d required 0",
                     rsp_rdata, spi_cmd_rnw, spi_cmd_addr, spi_cmd_wdata, timeout_cnt);
        end
        req_valid = 3'b000;
        sysrst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_grant [6];
        logic [2:0] vmask [6];
        logic [2:0] rdy, rsp;
        logic [15:0] rdat;
        logic err;
        exp_grant = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b010};
        vmask     = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b010};
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, ADDR_W'(16'h0100 + i), DATA_W'(16'h0A00 + i));
        for (int k = 0; k < 6; k++) begin
            run_txn(vmask[k], 16'h1111, rdy, rsp, rdat, err);
            checks++;
            if (rdy !== exp_grant[k]) begin
                failures++;
                $display("FAIL rr_grant[%0d]: req_ready=%b required %b", k, rdy, exp_grant[k]);
            end
            checks++;
            if (rsp !== exp_grant[k]) begin
                failures++;
                $display("FAIL rr_rsp[%0d]: rsp_valid=%b required %b", k, rsp, exp_grant[k]);
            end
            $display("rr txn %0d: grant=%b rsp=%b", k, rdy, rsp);
        end
        req_valid = 3'b000;
    endtask

    task automatic test_single_write();
        set_req(0, 1'b0, 15'h3800, 16'h0001);
        req_valid = 3'b001;
        spi_cmd_ready = 1'b1;
        tick();
        checks++;
        if (req_ready !== 3'b001 || spi_cmd_valid !== 1'b1 || busy !== 1'b1 || owner !== 3'd0) begin
            failures++;
            $display("FAIL wr_grant: req_ready=%b cmd_valid=%b busy=%b owner=%0d required 001/1/1/0",
                     req_ready, spi_cmd_valid, busy, owner);
        end
        checks++;
        if (spi_cmd_addr !== 15'h3800 || spi_cmd_wdata !== 16'h0001 || spi_cmd_rnw !== 1'b0) begin
            failures++;
            $display("FAIL wr_cmd: addr=%h wdata=%h rnw=%b required 3800/0001/0", spi_cmd_addr, spi_cmd_wdata, spi_cmd_rnw);
        end
        req_valid = 3'b000;
        tick();
        checks++;
        if (spi_cmd_valid !== 1'b0 || req_ready !== 3'b000) begin
            failures++;
            $display("FAIL wr_issue_drop: cmd_valid=%b req_ready=%b required 0/000", spi_cmd_valid, req_ready);
        end
        spi_done = 1'b1;
        spi_rdata = 16'hBEEF;
        tick();
        spi_done = 1'b0;
        checks++;
        if (rsp_valid !== 3'b001 || rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL wr_rsp: rsp_valid=%b rsp_error=%b required 001/0", rsp_valid, rsp_error);
        end
        $display("write txn: rsp_valid=%b rsp_error=%b", rsp_valid, rsp_error);
        tick();
        checks++;
        if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_idle: rsp_valid=%b busy=%b required 000/0", rsp_valid, busy);
        end
    endtask

    task automatic test_read_data();
        logic [2:0] rdy, rsp;
        logic [15:0] rdat;
        logic err;
        set_req(2, 1'b1, 15'h3000, 16'h0000);
        run_txn(3'b100, 16'h0358, rdy, rsp, rdat, err);
        req_valid = 3'b000;
        checks++;
        if (rdy !== 3'b100 || rsp !== 3'b100) begin
            failures++;
            $display("FAIL rd_onehot: req_ready=%b rsp_valid=%b required 100/100", rdy, rsp);
        end
        checks++;
        if (rdat !== 16'h0358 || err !== 1'b0) begin
            failures++;
            $display("FAIL rd_data: rsp_rdata=%h rsp_error=%b required 0358/0", rdat, err);
        end
        $display("read txn: rsp_valid=%b rdata=%h", rsp, rdat);
    endtask

    task automatic test_backpressure_timeout();
        logic bad;
        set_req(0, 1'b1, 15'h1234, 16'h5678);
        req_valid = 3'b001;
        spi_cmd_ready = 1'b0;
        tick();
        req_valid = 3'b000;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (spi_cmd_valid !== 1'b1 || spi_cmd_addr !== 15'h1234 || spi_cmd_wdata !== 16'h5678 ||
                spi_cmd_rnw !== 1'b1 || spi_abort !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad !== 1'b0 || spi_cmd_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_stable: cmd_valid=%b addr=%h required stable 1/1234 over 50 cycles", spi_cmd_valid, spi_cmd_addr);
        end
        spi_cmd_ready = 1'b1;
        tick();
        spi_cmd_ready = 1'b0;
        bad = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            if (spi_abort !== 1'b0 || rsp_valid !== 3'b000 || busy !== 1'b1) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad !== 1'b0 || spi_abort !== 1'b0) begin
            failures++;
            $display("FAIL to_early: spi_abort=%b rsp_valid=%b before %0d WAIT cycles", spi_abort, rsp_valid, TIMEOUT);
        end
        tick();
        checks++;
        if (spi_abort !== 1'b1 || rsp_valid !== 3'b000) begin
            failures++;
            $display("FAIL to_abort: spi_abort=%b rsp_valid=%b required 1/000", spi_abort, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 3'b001 || rsp_error !== 1'b1 || rsp_rdata !== 16'h0000 ||
            spi_abort !== 1'b0 || timeout_cnt !== 16'd1) begin
            failures++;
            $display("FAIL to_rsp: rsp_valid=%b err=%b rdata=%h abort=%b timeout_cnt=%0d required 001/1/0000/0/1",
                     rsp_valid, rsp_error, rsp_rdata, spi_abort, timeout_cnt);
        end
        $display("timeout txn: rsp_valid=%b rsp_error=%b timeout_cnt=%0d", rsp_valid, rsp_error, timeout_cnt);
        tick();
        spi_done = 1'b1;
        spi_rdata = 16'hFFFF;
        tick();
        spi_done = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 3'b000 || busy !== 1'b0 || rsp_rdata !== 16'h0000) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL late_done: rsp_valid=%b busy=%b rdata=%h required 000/0/0000", rsp_valid, busy, rsp_rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        set_req(1, 1'b0, 15'h0042, 16'h00AA);
        req_valid = 3'b010;
        spi_cmd_ready = 1'b1;
        tick();
        checks++;
        if (req_ready !== 3'b010) begin
            failures++;
            $display("FAIL rw_grant: req_ready=%b required 010", req_ready);
        end
        req_valid = 3'b000;
        tick();
        sysrst = 1'b1;
        spi_done = 1'b1;
        tick();
        sysrst = 1'b0;
        spi_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 3'b000 || owner !== 3'd0 || timeout_cnt !== 16'd0 ||
            spi_cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rw_reset: busy=%b rsp_valid=%b owner=%0d timeout_cnt=%0d cmd_valid=%b required 0/000/0/0/0",
                     busy, rsp_valid, owner, timeout_cnt, spi_cmd_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 3'b000) begin
            failures++;
            $display("FAIL rw_no_rsp: rsp_valid=%b required 000", rsp_valid);
        end
        req_valid = 3'b111;
        tick();
        checks++;
        if (req_ready !== 3'b001 || owner !== 3'd0) begin
            failures++;
            $display("FAIL rw_first_prio: req_ready=%b owner=%0d required 001/0", req_ready, owner);
        end
        $display("post-reset grant: req_ready=%b", req_ready);
        req_valid = 3'b000;
        tick();
        spi_done = 1'b1;
        spi_rdata = 16'h0000;
        tick();
        spi_done = 1'b0;
        tick();
    endtask

    initial begin
        sysrst = 1'b1;
        req_valid = '0;
        req_rnw = '0;
        req_addr = '0;
        req_wdata = '0;
        spi_cmd_ready = 1'b0;
        spi_done = 1'b0;
        spi_rdata = '0;
        test_reset();
        test_round_robin();
        test_single_write();
        test_read_data();
        test_backpressure_timeout();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
